md_unit: RTL

Parametrised multi-cycle multiply/divide unit with HI/LO state, sitting beside the ALU in the EX stage of the five-stage pipeline. It accepts one operation per `start` pulse, holds `busy` for a configurable number of cycles, and commits the result to HI/LO atomically on completion. It supports pipeline flush of an in-flight operation and drives the stall request that hazard control uses to hold IF/ID and bubble ID/EX.

---
 rtl/md_unit.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO state.
// Multiply-class ops are busy for MUL_CYCLES and divides for DIV_CYCLES.
// The product is registered on entry. The divider is a restoring
// shift-subtract engine that produces one quotient bit per cycle.
// HI/LO are written in a single edge when the operation completes.
// Optional feature: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 6-9).
// When it is undefined, those ops are no-ops and no accumulator adder exists.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int ITER_W  = $clog2(WIDTH) + 1;
    localparam int W2      = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN_MUL = 2'd1,
        S_RUN_DIV = 2'd2
    } state_e;

    // Ops that occupy the multiplier. The accumulate ops count only when built in.
    function automatic logic is_mul_op(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU: is_mul_op = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_op = 1'b1;
`endif
            default: is_mul_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        is_div_op = (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_mul(input logic [3:0] o);
        is_signed_mul = (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             launch_mul, launch_div, commit, mt_hi, mt_lo;
    logic             commit_mul, commit_div;

    logic [WIDTH-1:0] hi_q, lo_q;

    // Multiply datapath
    logic [W2-1:0]    a_ext, b_ext, prod_in, prod_q, mul_result;
`ifdef MD_MADD_EN
    logic [3:0]       op_q;
`endif

    // Divide datapath
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_q, dvsr_q, rem_q, quo_q;
    logic [ITER_W-1:0] iter_q;
    logic             quo_neg_q, rem_neg_q, dz_q;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge, iter_done;
    logic [WIDTH-1:0] rem_step, quo_step, rem_fin, quo_fin, div_hi, div_lo;

    // State register and latency counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and control strobes
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        launch_mul = 1'b0;
        launch_div = 1'b0;
        commit     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul_op(op)) begin
                            launch_mul = 1'b1;
                            state_d    = S_RUN_MUL;
                            cnt_d      = CNT_W'(MUL_CYCLES);
                        end else if (is_div_op(op)) begin
                            launch_div = 1'b1;
                            state_d    = S_RUN_DIV;
                            cnt_d      = CNT_W'(DIV_CYCLES);
                        end else if (op == OP_MTHI) begin
                            mt_hi = 1'b1;
                        end else if (op == OP_MTLO) begin
                            mt_lo = 1'b1;
                        end
                    end
                end
                S_RUN_MUL, S_RUN_DIV: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign commit_mul = commit && (state_q == S_RUN_MUL);
    assign commit_div = commit && (state_q == S_RUN_DIV);

    // Operand extension and full-width product of the incoming operands
    always_comb begin
        if (is_signed_mul(op)) begin
            a_ext = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            a_ext = {{WIDTH{1'b0}}, a};
            b_ext = {{WIDTH{1'b0}}, b};
        end
        prod_in = a_ext * b_ext;
    end

    // Multiply result: the plain product or the accumulate against current HI/LO
    always_comb begin
        mul_result = prod_q;
`ifdef MD_MADD_EN
        case (op_q)
            OP_MADD, OP_MADDU: mul_result = {hi_q, lo_q} + prod_q;
            OP_MSUB, OP_MSUBU: mul_result = {hi_q, lo_q} - prod_q;
            default:           mul_result = prod_q;
        endcase
`endif
    end

    // Sign conditioning of the divide operands (unsigned ops never negate)
    always_comb begin
        a_neg = (op == OP_DIV) && a[WIDTH-1];
        b_neg = (op == OP_DIV) && b[WIDTH-1];
    end

    // One restoring-division step plus final sign fix and divide-by-zero override
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvsr_q});
        rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - dvsr_q) : rem_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], rem_ge};
        iter_done = (iter_q == ITER_W'(WIDTH));
        // When DIV_CYCLES equals WIDTH the last step lands on the commit edge.
        quo_fin   = iter_done ? quo_q : quo_step;
        rem_fin   = iter_done ? rem_q : rem_step;
        if (dz_q) begin
            div_lo = '1;
            div_hi = a_q;
        end else begin
            div_lo = quo_neg_q ? -quo_fin : quo_fin;
            div_hi = rem_neg_q ? -rem_fin : rem_fin;
        end
    end

    // Operand latches and divide engine
    always_ff @(posedge clk) begin
        // NOTE: these datapath registers are deliberately not reset; they are
        // always loaded on launch before being read, so a reset adds nothing.
        if (launch_mul) begin
            prod_q <= prod_in;
`ifdef MD_MADD_EN
            op_q   <= op;
`endif
        end
        if (launch_div) begin
            a_q       <= a;
            dz_q      <= (b == '0);
            quo_q     <= a_neg ? -a : a;
            dvsr_q    <= b_neg ? -b : b;
            rem_q     <= '0;
            iter_q    <= '0;
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
        end else if (state_q == S_RUN_DIV && !iter_done) begin
            quo_q  <= quo_step;
            rem_q  <= rem_step;
            iter_q <= iter_q + ITER_W'(1);
        end
    end

    // Architectural HI/LO: direct moves or an atomic commit at completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mt_hi) begin
            hi_q <= a;
        end else if (mt_lo) begin
            lo_q <= a;
        end else if (commit_mul) begin
            hi_q <= mul_result[W2-1:WIDTH];
            lo_q <= mul_result[WIDTH-1:0];
        end else if (commit_div) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign stall_req = busy | (start & (is_mul_op(op) | is_div_op(op)));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
